// File: rtl/sq_bit_feeder_if.sv
// ---------------------------------------------------------------------------
// sq_bit_feeder_if
// Groups the two streaming sides of the SQ bit feeder:
//   byte FIFO side : rdata (show-ahead head), rempty, rinc (pop)
//   SQ bit side    : bit_req (request), fetch (transfer strobe), bit_data
// `bit` is a reserved word in SystemVerilog, so the SQ bit line is carried
// as bit_data.
// Modports:
//   master - the feeder: consumes FIFO bytes, produces bits for SQ
//   slave  - the environment: FIFO plus SQ decoder
// ---------------------------------------------------------------------------
interface sq_bit_feeder_if;
  logic [7:0] rdata;
  logic       rempty;
  logic       rinc;
  logic       bit_req;
  logic       fetch;
  logic       bit_data;

  modport master (
    input  rdata,
    input  rempty,
    output rinc,
    input  bit_req,
    output fetch,
    output bit_data
  );

  modport slave (
    output rdata,
    output rempty,
    input  rinc,
    output bit_req,
    input  fetch,
    input  bit_data
  );
endinterface

// File: rtl/sq_bit_feeder.sv
// ---------------------------------------------------------------------------
// sq_bit_feeder
// Byte-to-bit serializer in front of the SQ symbol decoder. Packed bytes are
// popped from a show-ahead FIFO into a two-slot buffer (cur/nxt) and handed
// to SQ one bit per cycle. Each frame carries a bit budget; bits of a byte
// left over at frame end, or on an align request, are discarded so that
// every frame and every aligned point starts on a byte boundary.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          begin a frame (honoured only when idle)
//   frame_bits     frame length in bits, sampled with start
//   align          drop the rest of the current byte (running only)
//   bus            sq_bit_feeder_if.master: FIFO pop side and SQ bit side
//   busy           frame in progress
//   done           one-cycle end-of-frame pulse
//   bits_left      bits remaining in the current frame
//
// Build option:
//   SQ_FEED_MSB_FIRST_EN  when defined, bits leave each byte MSB-first;
//                         otherwise LSB-first (SQ encoder order).
// ---------------------------------------------------------------------------
module sq_bit_feeder (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            frame_bits,
  input  logic                   align,
  sq_bit_feeder_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            bits_left
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Two-slot byte buffer; idx is the next bit position inside cur.
  logic [7:0]  cur;
  logic [7:0]  nxt;
  logic        cur_v;
  logic        nxt_v;
  logic [2:0]  idx;

  logic [7:0]  cur_d;
  logic [7:0]  nxt_d;
  logic        cur_v_d;
  logic        nxt_v_d;
  logic [2:0]  idx_d;
  logic [15:0] bits_left_d;
  logic        busy_d;
  logic        done_d;

  logic        run;
  logic        fetch;
  logic        last_bit;
  logic        byte_end;
  logic        align_hit;
  logic        tail_drop;
  logic        cur_free;
  logic        rinc;
  logic        frame_go;
  logic        frame_nil;

  // Selects the outgoing bit of a byte at position i in the build's bit order.
  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i);
`ifdef SQ_FEED_MSB_FIRST_EN
    pick_bit = b[3'd7 - i];
`else
    pick_bit = b[i];
`endif
  endfunction

  // Transfer qualification, byte retirement and FIFO pop decision.
  always_comb begin
    run       = (state == ST_RUN);
    fetch     = run & cur_v & bus.bit_req & (bits_left != 16'd0);
    last_bit  = fetch & (bits_left == 16'd1);
    byte_end  = fetch & (idx == 3'd7);
    // Align only matters on a partly used byte; at idx 0 nothing is dropped.
    align_hit = run & align & cur_v & (idx != 3'd0);
    // Last bit of the frame inside a byte: the byte tail is thrown away.
    tail_drop = last_bit & (idx != 3'd7);
    cur_free  = byte_end | align_hit | tail_drop;
    // Popping is allowed whenever a slot is, or becomes, free; gated by reset
    // so no byte is lost while the buffer is being cleared.
    rinc      = rst_n & ~bus.rempty & (~cur_v | ~nxt_v | cur_free);
    frame_go  = (state == ST_IDLE) & start & (frame_bits != 16'd0);
    frame_nil = (state == ST_IDLE) & start & (frame_bits == 16'd0);
  end

  // Frame FSM next state plus the registered busy/done values.
  always_comb begin
    state_nxt = state;
    done_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_go) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
        done_d = frame_nil;
      end
      ST_RUN: begin
        if (last_bit) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RUN;
        end
        done_d = last_bit;
      end
      default: begin
        state_nxt = ST_IDLE;
        done_d    = 1'b0;
      end
    endcase
    busy_d = (state_nxt == ST_RUN);
  end

  // Slot refill: a freed cur takes nxt first, else the FIFO head; an empty
  // nxt behind a valid cur takes the FIFO head.
  always_comb begin
    cur_d   = cur;
    nxt_d   = nxt;
    cur_v_d = cur_v;
    nxt_v_d = nxt_v;
    if (cur_free) begin
      if (nxt_v) begin
        cur_d   = nxt;
        cur_v_d = 1'b1;
        if (rinc) begin
          nxt_d   = bus.rdata;
          nxt_v_d = 1'b1;
        end else begin
          nxt_v_d = 1'b0;
        end
      end else begin
        if (rinc) begin
          cur_d   = bus.rdata;
          cur_v_d = 1'b1;
        end else begin
          cur_v_d = 1'b0;
        end
      end
    end else if (!cur_v) begin
      if (rinc) begin
        cur_d   = bus.rdata;
        cur_v_d = 1'b1;
      end else begin
        cur_v_d = 1'b0;
      end
    end else begin
      if (!nxt_v && rinc) begin
        nxt_d   = bus.rdata;
        nxt_v_d = 1'b1;
      end else begin
        nxt_v_d = nxt_v;
      end
    end
  end

  // Bit index and frame budget; a freed byte always restarts at bit 0.
  always_comb begin
    if (cur_free) begin
      idx_d = 3'd0;
    end else if (fetch) begin
      idx_d = idx + 3'd1;
    end else begin
      idx_d = idx;
    end

    if (frame_go) begin
      bits_left_d = frame_bits;
    end else if (fetch) begin
      bits_left_d = bits_left - 16'd1;
    end else begin
      bits_left_d = bits_left;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte buffer, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= 8'd0;
      nxt       <= 8'd0;
      cur_v     <= 1'b0;
      nxt_v     <= 1'b0;
      idx       <= 3'd0;
      bits_left <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur       <= cur_d;
      nxt       <= nxt_d;
      cur_v     <= cur_v_d;
      nxt_v     <= nxt_v_d;
      idx       <= idx_d;
      bits_left <= bits_left_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign bus.rinc     = rinc;
  assign bus.fetch    = fetch;
  assign bus.bit_data = cur_v ? pick_bit(cur, idx) : 1'b0;

endmodule
